// File: rtl/io_serdes_pkg.sv
// io_serdes_pkg: state encoding and beat-count helper shared by the stream serdes
package io_serdes_pkg;
  typedef logic [1:0] state_t;
  localparam state_t LOAD = 2'd0;
  localparam state_t CALC = 2'd1;
  localparam state_t OUT = 2'd2;
  function automatic int beats(input int width, input int bus);
    return width / bus;
  endfunction
endpackage

// File: rtl/io_serdes_shreg.sv
// io_serdes_shreg: beat-wide shift register with parallel load and clear
module io_serdes_shreg import io_serdes_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int BUS = 8,
  parameter bit MSB_FIRST = 1
)(
  input logic clk,
  input logic reset,
  input logic clear,
  input logic load,
  input logic shift,
  input logic [WIDTH-1:0] load_data,
  input logic [BUS-1:0] din,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] shifted;
  // the same shift direction serves both shift-in and shift-out (din = 0)
  assign shifted = MSB_FIRST ? (q << BUS) | WIDTH'(din) : (q >> BUS) | (WIDTH'(din) << (WIDTH - BUS));
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else if (clear) q <= '0;
    else if (load) q <= load_data;
    else if (shift) q <= shifted;
endmodule

// File: rtl/io_serdes_stream.sv
// io_serdes_stream: deserialise operands, pulse start_calc, serialise the core result back out
module io_serdes_stream import io_serdes_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int BUS = 8,
  parameter int N_OPS = 2,
  parameter bit MSB_FIRST = 1
)(
  input logic clk,
  input logic reset,
  input logic [BUS-1:0] inputs,
  input logic in_valid,
  output logic in_ready,
  output logic [N_OPS*WIDTH-1:0] operands,
  output logic start_calc,
  input logic calc_done,
  input logic [WIDTH-1:0] z,
  output logic [BUS-1:0] outputs,
  output logic out_valid,
  input logic out_ready,
  input logic abort,
  output logic busy
);
  localparam int BEATS = beats(WIDTH, BUS);
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int OW = N_OPS > 1 ? $clog2(N_OPS) : 1;
  if (WIDTH % BUS != 0 || N_OPS < 1) begin : g_bad_params
    $error("io_serdes_stream: WIDTH must be a multiple of BUS and N_OPS must be >= 1");
  end
  state_t state;
  logic [CW-1:0] beat_cnt, beat_nxt;
  logic [OW-1:0] op_cnt;
  logic in_xfer, out_xfer, last_beat, last_op, res_load;
  logic [WIDTH-1:0] res_q;
  logic [BUS-1:0] res_beat;
  assign in_ready = state == LOAD;
  assign out_valid = state == OUT;
  assign in_xfer = in_valid && in_ready && !abort;
  assign out_xfer = out_valid && out_ready && !abort;
  assign last_beat = beat_cnt == CW'(BEATS - 1);
  assign last_op = op_cnt == OW'(N_OPS - 1);
  assign beat_nxt = last_beat ? '0 : beat_cnt + CW'(1);
  assign res_load = state == CALC && calc_done && !abort;
  assign res_beat = BUS'(MSB_FIRST ? res_q >> (WIDTH - BUS) : res_q);
  assign outputs = out_valid ? res_beat : '0;
  assign busy = state != LOAD || beat_cnt != '0 || op_cnt != '0;
  for (genvar k = 0; k < N_OPS; k++) begin : g_op
    io_serdes_shreg #(.WIDTH(WIDTH), .BUS(BUS), .MSB_FIRST(MSB_FIRST)) u_op (
      .clk(clk), .reset(reset), .clear(1'b0), .load(1'b0),
      .shift(in_xfer && op_cnt == OW'(k)), .load_data('0), .din(inputs),
      .q(operands[k*WIDTH +: WIDTH])
    );
  end
  io_serdes_shreg #(.WIDTH(WIDTH), .BUS(BUS), .MSB_FIRST(MSB_FIRST)) u_res (
    .clk(clk), .reset(reset), .clear(abort), .load(res_load),
    .shift(out_xfer), .load_data(z), .din('0), .q(res_q)
  );
  // beat_cnt is shared: it counts input beats in LOAD and output beats in OUT
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= LOAD;
      beat_cnt <= '0;
      op_cnt <= '0;
      start_calc <= 1'b0;
    end else if (abort) begin
      state <= LOAD;
      beat_cnt <= '0;
      op_cnt <= '0;
      start_calc <= 1'b0;
    end else begin
      start_calc <= in_xfer && last_beat && last_op;
      if (in_xfer) begin
        beat_cnt <= beat_nxt;
        if (last_beat) op_cnt <= last_op ? '0 : op_cnt + OW'(1);
        if (last_beat && last_op) state <= CALC;
      end
      if (res_load) state <= OUT;
      if (out_xfer) begin
        beat_cnt <= beat_nxt;
        if (last_beat) state <= LOAD;
      end
    end
endmodule

// File: tb/tb_io_serdes_stream.sv
// tb_io_serdes_stream: table-driven load/calc/unload cases with an output-beat scoreboard
module tb_io_serdes_stream;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic [7:0] inputs = '0;
  logic in_valid = 1'b0, in_ready;
  logic [63:0] operands;
  logic start_calc, calc_done = 1'b0;
  logic [31:0] z = '0;
  logic [7:0] outputs;
  logic out_valid, out_ready = 1'b0, abort = 1'b0, busy;
  io_serdes_stream dut (
    .clk(clk), .reset(reset), .inputs(inputs), .in_valid(in_valid), .in_ready(in_ready),
    .operands(operands), .start_calc(start_calc), .calc_done(calc_done), .z(z),
    .outputs(outputs), .out_valid(out_valid), .out_ready(out_ready), .abort(abort), .busy(busy)
  );
  logic [7:0] r_in = '0;
  logic r_iv = 1'b0, r_ir;
  logic [71:0] r_ops;
  logic r_sc, r_done = 1'b0;
  logic [23:0] r_z = '0;
  logic [7:0] r_out;
  logic r_ov, r_ordy = 1'b0, r_busy;
  io_serdes_stream #(.WIDTH(24), .BUS(8), .N_OPS(3), .MSB_FIRST(0)) dut24 (
    .clk(clk), .reset(reset), .inputs(r_in), .in_valid(r_iv), .in_ready(r_ir),
    .operands(r_ops), .start_calc(r_sc), .calc_done(r_done), .z(r_z),
    .outputs(r_out), .out_valid(r_ov), .out_ready(r_ordy), .abort(1'b0), .busy(r_busy)
  );
  typedef struct {
    logic [31:0] op0, op1, z;
    bit gap;
    int dly;
    logic [7:0] rdy;
    int n_cyc;
  } vec_t;
  vec_t tbl [5];
  int checks = 0, errors = 0, sc_cnt = 0, popped = 0;
  logic [7:0] sb [$];
  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (start_calc) sc_cnt++;
    if (out_valid && out_ready && !abort) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_extra: got beat %h with nothing expected", outputs);
      end else begin
        chk("out_beat", outputs, sb.pop_front());
        popped++;
      end
    end else if (!out_valid) chk("out_idle", outputs, 0);
  end
  task automatic load8(input logic [63:0] s, input bit gap);
    for (int i = 0; i < 8; i++) begin
      if (gap && i > 0) begin
        in_valid = 1'b0;
        tick();
      end
      inputs = s[63-8*i -: 8];
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    inputs = '0;
  endtask
  task automatic run_case(input vec_t v);
    int n;
    sc_cnt = 0;
    popped = 0;
    load8({v.op0, v.op1}, v.gap);
    chk("start_early", sc_cnt, 0);
    chk("start_calc", start_calc, 1);
    chk("operands", operands, {v.op1, v.op0});
    chk("in_ready_calc", in_ready, 0);
    chk("busy_calc", busy, 1);
    for (int i = 0; i < v.dly; i++) begin
      tick();
      chk("start_drop", start_calc, 0);
      chk("calc_wait", out_valid, 0);
    end
    calc_done = 1'b1;
    z = v.z;
    for (int b = 0; b < 4; b++) sb.push_back(v.z[31-8*b -: 8]);
    tick();
    calc_done = 1'b0;
    chk("start_pulses", sc_cnt, 1);
    chk("out_valid", out_valid, 1);
    n = 0;
    while (popped < 4 && n < 30) begin
      out_ready = n < 8 ? v.rdy[n] : 1'b1;
      tick();
      n++;
    end
    out_ready = 1'b0;
    chk("out_cycles", n, v.n_cyc);
    chk("sb_empty", sb.size(), 0);
    chk("done_valid", out_valid, 0);
    chk("done_ready", in_ready, 1);
    chk("done_busy", busy, 0);
  endtask
  initial begin
    tbl = '{
      '{32'hDEADBEEF, 32'h01234567, 32'hCAFEF00D, 1'b0, 5, 8'hFF, 4},
      '{32'hDEADBEEF, 32'h01234567, 32'hCAFEF00D, 1'b1, 5, 8'hFF, 4},
      '{32'hDEADBEEF, 32'h01234567, 32'hCAFEF00D, 1'b0, 2, 8'hE9, 7},
      '{32'hA5A55A5A, 32'h0F0F00FF, 32'h12345678, 1'b0, 0, 8'hFF, 4},
      '{32'h11223344, 32'h55667788, 32'h89ABCDEF, 1'b1, 1, 8'hFF, 4}
    };
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", outputs, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", start_calc, 0);
    chk("rst_operands", operands, 0);
    reset = 1'b0;
    tick();
    for (int t = 0; t < 4; t++) run_case(tbl[t]);
    // abort after three beats; the partial operand keeps its shifted bits
    for (int i = 0; i < 3; i++) begin
      inputs = 8'hDE - 8'(i == 1 ? 8'h31 : (i == 2 ? 8'h20 : 8'h00));
      in_valid = 1'b1;
      tick();
    end
    chk("abort_busy_before", busy, 1);
    abort = 1'b1;
    inputs = 8'hEF;
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_partial", operands[31:0], 32'h5ADEADBE);
    run_case(tbl[4]);
    // async reset in the middle of OUT
    load8(64'hDEADBEEF01234567, 1'b0);
    calc_done = 1'b1;
    z = 32'hCAFEF00D;
    tick();
    calc_done = 1'b0;
    tick();
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_beat", outputs, 8'hCA);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_outputs", outputs, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", in_ready, 1);
    tick();
    reset = 1'b0;
    tick();
    // 24-bit, three operands, least-significant beat first
    for (int i = 0; i < 9; i++) begin
      r_in = 8'(8'h11 * (i + 1));
      r_iv = 1'b1;
      tick();
    end
    r_iv = 1'b0;
    chk("w24_start", r_sc, 1);
    chk("w24_operands", r_ops, 72'h998877665544332211);
    r_done = 1'b1;
    r_z = 24'hABCDEF;
    tick();
    r_done = 1'b0;
    r_ordy = 1'b1;
    chk("w24_beat0", r_out, 8'hEF);
    chk("w24_valid", r_ov, 1);
    tick();
    chk("w24_beat1", r_out, 8'hCD);
    tick();
    chk("w24_beat2", r_out, 8'hAB);
    tick();
    chk("w24_done_valid", r_ov, 0);
    chk("w24_done_busy", r_busy, 0);
    chk("w24_done_ready", r_ir, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
